// File: rtl/ahb_bus_arbiter_if.sv
// Bus-side signals between the AHB masters and the round-robin arbiter.
// master modport: the requesting side; slave modport: the arbiter itself.
interface ahb_bus_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int MW          = 1
);
    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    logic [1:0]             HTRANS;
    logic                   HBURST;
    logic                   HREADY;
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [MW-1:0]          HMASTER;
    logic                   HMASTLOCK;

    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        input  HGRANT, HMASTER, HMASTLOCK
    );

    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        output HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter with burst/lock hold and park on master 0.
// Optional tenure limit enabled by defining AHB_ARB_TIMEOUT_EN.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int MW          = 1,
    parameter int MAX_BEATS   = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    ahb_bus_arbiter_if.slave bus
);
    localparam logic [1:0] ST_PARK   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [NUM_MASTERS-1:0] PARK_GRANT = NUM_MASTERS'(1);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || MW != $clog2(NUM_MASTERS) || MAX_BEATS < 1) begin : g_bad_params
        $error("ahb_bus_arbiter: unsupported NUM_MASTERS/MW/MAX_BEATS combination");
    end

    logic [1:0]             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [MW-1:0]          master_q, master_d;
    logic                   mastlock_q, mastlock_d;

    logic [MW-1:0]          owner_idx;
    logic                   owner_lock;
    logic                   burst_hold;
    logic                   force_arb;
    logic                   arb_point;
    logic                   do_arb;

    logic [MW-1:0]          cand_idx [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] cand_req;
    logic                   win_found;
    logic [MW-1:0]          win_idx;

    // Candidate gi is the master gi+1 places after the last winner, wrapping.
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
        assign cand_idx[gi] = MW'((int'(rr_ptr_q) + gi + 1) % NUM_MASTERS);
        assign cand_req[gi] = bus.HBUSREQ[cand_idx[gi]];
    end

    always_comb begin
        win_found = |cand_req;
        win_idx   = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                win_idx = cand_idx[k];
            end
        end
    end

    always_comb begin
        owner_idx = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
                owner_idx = MW'(k);
            end
        end
    end

    assign owner_lock = bus.HLOCK[owner_idx];
    assign burst_hold = (bus.HTRANS == TR_SEQ) || (bus.HTRANS == TR_BUSY) ||
                        ((bus.HTRANS == TR_NONSEQ) && bus.HBURST);

`ifdef AHB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_BEATS + 1);

    logic [CW-1:0] beat_cnt_q, beat_cnt_d;

    // An owner that has used up its tenure is cut off mid-burst if anyone else waits.
    assign force_arb = (beat_cnt_q == CW'(MAX_BEATS)) && (state_q == ST_GRANT) &&
                       (|(bus.HBUSREQ & ~grant_q));

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (grant_d != grant_q) begin
            beat_cnt_d = '0;
        end else if (bus.HREADY && bus.HTRANS[1] && (beat_cnt_q != CW'(MAX_BEATS))) begin
            beat_cnt_d = beat_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`else
    assign force_arb = 1'b0;
`endif

    assign arb_point = bus.HREADY && (!burst_hold || force_arb);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        master_d   = master_q;
        mastlock_d = mastlock_q;
        do_arb     = 1'b0;
        if (bus.HREADY) begin
            // Address-phase handover trails the grant by one accepted cycle.
            master_d   = owner_idx;
            mastlock_d = owner_lock;
            if (arb_point) begin
                case (state_q)
                    ST_LOCKED: do_arb = !owner_lock;
                    ST_GRANT: begin
                        if (owner_lock) begin
                            state_d = ST_LOCKED;
                        end else begin
                            do_arb = 1'b1;
                        end
                    end
                    default: do_arb = 1'b1;
                endcase
            end
            if (do_arb) begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    rr_ptr_d         = win_idx;
                    state_d          = ST_GRANT;
                end else begin
                    grant_d = PARK_GRANT;
                    state_d = ST_PARK;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= ST_PARK;
            grant_q    <= PARK_GRANT;
            rr_ptr_q   <= '0;
            master_q   <= '0;
            mastlock_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            master_q   <= master_d;
            mastlock_q <= mastlock_d;
        end
    end

    assign bus.HGRANT    = grant_q;
    assign bus.HMASTER   = master_q;
    assign bus.HMASTLOCK = mastlock_q;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter (2 masters, MAX_BEATS=4); expected
// grants are table constants, HMASTER/HMASTLOCK follow the grant one ready cycle later.
module tb_ahb_bus_arbiter;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] NSEQ = 2'b10;
    localparam logic [1:0] SEQ  = 2'b11;
`ifdef AHB_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic HCLK = 1'b0;
    logic HRESET;

    ahb_bus_arbiter_if #(.NUM_MASTERS(2), .MW(1)) bus ();

    ahb_bus_arbiter #(
        .NUM_MASTERS(2),
        .MW         (1),
        .MAX_BEATS  (4)
    ) dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .bus   (bus)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [1:0] grant;
        logic       master;
        logic       lock;
    } exp_t;

    exp_t sb_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;

    logic [1:0] m_grant  = 2'b01;
    logic       m_master = 1'b0;
    logic       m_lock   = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, push the expectation, clock, pop and compare.
    task automatic step(input string tag, input logic rst, input logic rdy,
                        input logic [1:0] req, input logic [1:0] lck,
                        input logic [1:0] trans, input logic burst,
                        input logic [1:0] exp_grant);
        exp_t e;
        HRESET      = rst;
        bus.HREADY  = rdy;
        bus.HBUSREQ = req;
        bus.HLOCK   = lck;
        bus.HTRANS  = trans;
        bus.HBURST  = burst;
        if (rst) begin
            m_master = 1'b0;
            m_lock   = 1'b0;
        end else if (rdy) begin
            m_master = m_grant[1];
            m_lock   = lck[m_grant[1]];
        end
        m_grant = exp_grant;
        e.grant  = exp_grant;
        e.master = m_master;
        e.lock   = m_lock;
        sb_q.push_back(e);
        @(posedge HCLK);
        #1;
        e = sb_q.pop_front();
        check({tag, "/grant"}, 8'(bus.HGRANT), 8'(e.grant));
        check({tag, "/hmaster"}, 8'(bus.HMASTER), 8'(e.master));
        check({tag, "/hmastlock"}, 8'(bus.HMASTLOCK), 8'(e.lock));
        check({tag, "/onehot"}, 8'($onehot(bus.HGRANT)), 8'd1);
        $display("%s rst=%b rdy=%b req=%b lock=%b trans=%b burst=%b -> grant=%b hmaster=%0d hmastlock=%b",
                 tag, rst, rdy, req, lck, trans, burst, bus.HGRANT, bus.HMASTER, bus.HMASTLOCK);
    endtask

    initial begin
        HRESET      = 1'b1;
        bus.HREADY  = 1'b1;
        bus.HBUSREQ = 2'b00;
        bus.HLOCK   = 2'b00;
        bus.HTRANS  = IDLE;
        bus.HBURST  = 1'b0;

        // Reset and idle parking on master 0
        for (int i = 0; i < 2; i++) step("t1_rst", 1, 1, 2'b00, 2'b00, IDLE, 0, 2'b01);
        for (int i = 0; i < 5; i++) step("t1_park", 0, 1, 2'b00, 2'b00, IDLE, 0, 2'b01);

        // Both requesting, single transfers: alternate each arb point
        step("t2_req", 0, 1, 2'b11, 2'b00, IDLE, 0, 2'b10);
        step("t2_x0",  0, 1, 2'b11, 2'b00, NSEQ, 0, 2'b01);
        step("t2_x1",  0, 1, 2'b11, 2'b00, NSEQ, 0, 2'b10);
        step("t2_x2",  0, 1, 2'b11, 2'b00, NSEQ, 0, 2'b01);
        step("t2_park", 0, 1, 2'b00, 2'b00, IDLE, 0, 2'b01);

        // M0 INCR burst, M1 requests at beat 2
        step("t3_rst", 1, 1, 2'b00, 2'b00, IDLE, 0, 2'b01);
        step("t3_req", 0, 1, 2'b01, 2'b00, IDLE, 0, 2'b01);
        step("t3_b1",  0, 1, 2'b01, 2'b00, NSEQ, 1, 2'b01);
        step("t3_b2",  0, 1, 2'b11, 2'b00, SEQ,  1, 2'b01);
        step("t3_b3",  0, 1, 2'b11, 2'b00, SEQ,  1, 2'b01);
        step("t3_b4",  0, 1, 2'b11, 2'b00, SEQ,  1, 2'b01);
        step("t3_b5",  0, 1, 2'b11, 2'b00, SEQ,  1, TMO ? 2'b10 : 2'b01);
        step("t3_b6",  0, 1, 2'b11, 2'b00, SEQ,  1, TMO ? 2'b10 : 2'b01);
        step("t3_end", 0, 1, 2'b11, 2'b00, IDLE, 0, TMO ? 2'b01 : 2'b10);

        // M1 locked sequence of three transfers
        step("t4_rst",  1, 1, 2'b00, 2'b00, IDLE, 0, 2'b01);
        step("t4_req",  0, 1, 2'b11, 2'b10, IDLE, 0, 2'b10);
        step("t4_lock", 0, 1, 2'b11, 2'b10, IDLE, 0, 2'b10);
        step("t4_x1",   0, 1, 2'b11, 2'b10, NSEQ, 0, 2'b10);
        step("t4_x2",   0, 1, 2'b11, 2'b10, NSEQ, 0, 2'b10);
        step("t4_x3",   0, 1, 2'b11, 2'b10, NSEQ, 0, 2'b10);
        step("t4_unlk", 0, 1, 2'b11, 2'b00, IDLE, 0, 2'b01);
        step("t4_x4",   0, 1, 2'b11, 2'b00, NSEQ, 0, 2'b10);
        step("t4_park", 0, 1, 2'b00, 2'b00, IDLE, 0, 2'b01);

        // Wait states freeze everything; reset wins over HREADY=0 mid-burst
        step("t5_rst", 1, 1, 2'b00, 2'b00, IDLE, 0, 2'b01);
        step("t5_req", 0, 1, 2'b01, 2'b00, IDLE, 0, 2'b01);
        step("t5_x0",  0, 1, 2'b01, 2'b00, NSEQ, 0, 2'b01);
        for (int i = 0; i < 4; i++) step("t5_wait", 0, 0, 2'b11, 2'b00, NSEQ, 0, 2'b01);
        step("t5_go",    0, 1, 2'b11, 2'b00, NSEQ, 0, 2'b10);
        step("t5_wait2", 0, 0, 2'b11, 2'b00, IDLE, 0, 2'b10);
        step("t5_go2",   0, 1, 2'b11, 2'b00, IDLE, 0, 2'b01);
        step("t5_m1",    0, 1, 2'b10, 2'b00, IDLE, 0, 2'b10);
        step("t5_keep",  0, 1, 2'b10, 2'b00, IDLE, 0, 2'b10);
        step("t5_b1",    0, 1, 2'b11, 2'b00, NSEQ, 1, 2'b10);
        step("t5_b2",    0, 1, 2'b11, 2'b00, SEQ,  1, 2'b10);
        step("t5_mrst",  1, 0, 2'b11, 2'b00, SEQ,  1, 2'b01);
        step("t5_rr",    0, 1, 2'b11, 2'b00, IDLE, 0, 2'b10);
        step("t5_park",  0, 1, 2'b00, 2'b00, IDLE, 0, 2'b01);

        // Ten-beat M0 INCR with M1 waiting: tenure limit only when enabled
        step("t6_rst", 1, 1, 2'b00, 2'b00, IDLE, 0, 2'b01);
        step("t6_req", 0, 1, 2'b01, 2'b00, IDLE, 0, 2'b01);
        step("t6_b1",  0, 1, 2'b11, 2'b00, NSEQ, 1, 2'b01);
        for (int i = 2; i <= 4; i++) step("t6_bx", 0, 1, 2'b11, 2'b00, SEQ, 1, 2'b01);
        for (int i = 5; i <= 9; i++) step("t6_by", 0, 1, 2'b11, 2'b00, SEQ, 1, TMO ? 2'b10 : 2'b01);
        step("t6_b10",  0, 1, 2'b11, 2'b00, SEQ,  1, 2'b01);
        step("t6_end",  0, 1, 2'b10, 2'b00, IDLE, 0, 2'b10);
        step("t6_park", 0, 1, 2'b00, 2'b00, IDLE, 0, 2'b01);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
